// File: rtl/tlb_plru.sv
// -----------------------------------------------------------------------------
// tlb_plru
//   Set-associative, PCID-tagged TLB with tree pseudo-LRU replacement per set.
//   Commands arrive on a valid/ready port and each produces one registered,
//   single-cycle response pulse. Lookups come from the core; inserts come
//   from the page walker after a miss.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous active-high reset
//   cmd_valid   command present
//   cmd_ready   block can accept a command (high only in IDLE)
//   cmd_op      00 lookup, 01 insert, 10 invalidate-by-PCID, 11 flush
//   cmd_va      virtual address (lookup/insert)
//   cmd_pa      physical address (insert; page-offset bits ignored)
//   cmd_pcid    PCID (lookup/insert/invalidate)
//   resp_valid  one-cycle response pulse
//   resp_hit    lookup: hit; insert: existing entry updated in place
//   resp_ta     translated address on a lookup hit, else 0
//   resp_way    way hit or written, else 0
// -----------------------------------------------------------------------------
module tlb_plru #(
    parameter int SADDR = 64,
    parameter int SPAGE = 12,
    parameter int NSET  = 8,
    parameter int NWAY  = 8,
    parameter int SPCID = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [SADDR-1:0]         cmd_va,
    input  logic [SADDR-1:0]         cmd_pa,
    input  logic [SPCID-1:0]         cmd_pcid,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic [SADDR-1:0]         resp_ta,
    output logic [$clog2(NWAY)-1:0]  resp_way
);

    localparam int SETW = $clog2(NSET);
    localparam int WAYW = $clog2(NWAY);
    localparam int TAGW = SADDR - SPAGE - SETW;
    localparam int PPNW = SADDR - SPAGE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_INSERT,
        S_INV,
        S_FLUSH
    } state_t;

    state_t state_q, state_d;

    // Registered command fields
    logic [SPAGE-1:0] q_ofs;
    logic [SETW-1:0]  q_set;
    logic [TAGW-1:0]  q_tag;
    logic [PPNW-1:0]  q_ppn;
    logic [SPCID-1:0] q_pcid;
    logic [SETW-1:0]  set_cnt_q;

    // Entry storage
    logic [NWAY-1:0]  valid_q  [NSET];
    logic [NWAY-2:0]  plru_q   [NSET];
    logic [TAGW-1:0]  tag_mem  [NSET][NWAY];
    logic [SPCID-1:0] pcid_mem [NSET][NWAY];
    logic [PPNW-1:0]  ppn_mem  [NSET][NWAY];

    // Lookup / way-selection results for the registered set
    logic            hit_any;
    logic [WAYW-1:0] hit_way;
    logic            free_any;
    logic [WAYW-1:0] free_way;
    logic [WAYW-1:0] victim_way;
    logic [WAYW-1:0] ins_way;

    logic accept;
    logic set_last;

    // The page-offset bits of the physical address carry no information.
    logic unused_pa_ofs;
    assign unused_pa_ofs = ^cmd_pa[SPAGE-1:0];

    assign accept   = cmd_valid && cmd_ready;
    assign set_last = (set_cnt_q == SETW'(NSET - 1));

    // Make every node on the root-to-leaf path point away from 'way'.
    // A node bit of 0 sends the victim search into the left subtree.
    function automatic logic [NWAY-2:0] plru_touch(input logic [NWAY-2:0] bits,
                                                    input logic [WAYW-1:0] way);
        logic [NWAY-2:0] r;
        logic [WAYW-1:0] node;
        logic            dir;
        r    = bits;
        node = '0;
        for (int l = 0; l < WAYW; l++) begin
            dir     = way[WAYW-1-l];
            r[node] = ~dir;
            node    = (node << 1) + WAYW'(1) + WAYW'(dir);
        end
        return r;
    endfunction

    // Follow the node bits from the root down to a leaf.
    function automatic logic [WAYW-1:0] plru_victim(input logic [NWAY-2:0] bits);
        logic [WAYW-1:0] v;
        logic [WAYW-1:0] node;
        logic            dir;
        v    = '0;
        node = '0;
        for (int l = 0; l < WAYW; l++) begin
            dir            = bits[node];
            v[WAYW-1-l]    = dir;
            node           = (node << 1) + WAYW'(1) + WAYW'(dir);
        end
        return v;
    endfunction

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred for state_d.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (cmd_op)
                        2'b00:   state_d = S_LOOKUP;
                        2'b01:   state_d = S_INSERT;
                        2'b10:   state_d = S_INV;
                        default: state_d = S_FLUSH;
                    endcase
                end
            end
            S_LOOKUP, S_INSERT, S_FLUSH: state_d = S_IDLE;
            S_INV:   if (set_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
    end

    // -------------------------------------------------------------------------
    // Parallel compare of all ways in the registered set, lowest index wins.
    // -------------------------------------------------------------------------
    always_comb begin
        hit_any  = 1'b0;
        hit_way  = '0;
        free_any = 1'b0;
        free_way = '0;
        for (int w = NWAY - 1; w >= 0; w--) begin
            if (valid_q[q_set][w] && (tag_mem[q_set][w] == q_tag) &&
                (pcid_mem[q_set][w] == q_pcid)) begin
                hit_any = 1'b1;
                hit_way = WAYW'(w);
            end
            if (!valid_q[q_set][w]) begin
                free_any = 1'b1;
                free_way = WAYW'(w);
            end
        end
        victim_way = plru_victim(plru_q[q_set]);
        // An existing match is updated in place so no duplicate is created.
        ins_way    = hit_any ? hit_way : (free_any ? free_way : victim_way);
    end

    // -------------------------------------------------------------------------
    // Control state: valid bits, PLRU, registered command, response
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NSET; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            q_ofs      <= '0;
            q_set      <= '0;
            q_tag      <= '0;
            q_ppn      <= '0;
            q_pcid     <= '0;
            set_cnt_q  <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_ta    <= '0;
            resp_way   <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            resp_valid <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        q_ofs     <= cmd_va[SPAGE-1:0];
                        q_set     <= cmd_va[SPAGE+SETW-1:SPAGE];
                        q_tag     <= cmd_va[SADDR-1:SPAGE+SETW];
                        q_ppn     <= cmd_pa[SADDR-1:SPAGE];
                        q_pcid    <= cmd_pcid;
                        set_cnt_q <= '0;
                    end
                end
                S_LOOKUP: begin
                    resp_valid <= 1'b1;
                    resp_hit   <= hit_any;
                    if (hit_any) begin
                        resp_ta       <= {ppn_mem[q_set][hit_way], q_ofs};
                        resp_way      <= hit_way;
                        plru_q[q_set] <= plru_touch(plru_q[q_set], hit_way);
                    end else begin
                        resp_ta  <= '0;
                        resp_way <= '0;
                    end
                end
                S_INSERT: begin
                    valid_q[q_set][ins_way] <= 1'b1;
                    plru_q[q_set]           <= plru_touch(plru_q[q_set], ins_way);
                    resp_valid              <= 1'b1;
                    resp_hit                <= hit_any;
                    resp_ta                 <= '0;
                    resp_way                <= ins_way;
                end
                S_INV: begin
                    // Clearing valid alone is enough; PLRU history is kept.
                    for (int w = 0; w < NWAY; w++) begin
                        if (pcid_mem[set_cnt_q][w] == q_pcid) begin
                            valid_q[set_cnt_q][w] <= 1'b0;
                        end
                    end
                    set_cnt_q <= set_cnt_q + 1'b1;
                    if (set_last) begin
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b0;
                        resp_ta    <= '0;
                        resp_way   <= '0;
                    end
                end
                S_FLUSH: begin
                    for (int s = 0; s < NSET; s++) begin
                        valid_q[s] <= '0;
                        plru_q[s]  <= '0;
                    end
                    resp_valid <= 1'b1;
                    resp_hit   <= 1'b0;
                    resp_ta    <= '0;
                    resp_way   <= '0;
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Entry payload arrays
    // -------------------------------------------------------------------------
    // NOTE: the tag/pcid/ppn arrays have no reset; an entry is only ever
    // observed through its valid bit, which is reset above.
    always_ff @(posedge clk) begin
        if (state_q == S_INSERT) begin
            tag_mem[q_set][ins_way]  <= q_tag;
            pcid_mem[q_set][ins_way] <= q_pcid;
            ppn_mem[q_set][ins_way]  <= q_ppn;
        end
    end

endmodule

// File: doc/tlb_plru.md
# tlb_plru

Set-associative, PCID-tagged translation lookaside buffer with generic tree pseudo-LRU replacement. It is the parametrised successor to the fixed 8-way TLB: way count is a power-of-two parameter, entries carry valid bits, and there is an explicit valid/ready command port and a registered response port. It also adds duplicate-free insert, invalidate-by-PCID and full flush. It sits between the address-generation stage and the page-walker: lookups come from the core, and inserts come from the walker after a miss.

## Interface
- SADDR, 64, address width (VA and PA)
- SPAGE, 12, page-offset width
- NSET, 8, number of sets (power of two, ≥2)
- NWAY, 8, ways per set (power of two, ≥2)
- SPCID, 12, PCID width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_op  in  2  00 lookup, 01 insert, 10 invalidate-by-PCID, 11 flush
- cmd_va  in  SADDR  virtual address (lookup/insert)
- cmd_pa  in  SADDR  physical address (insert; bits [SPAGE-1:0] ignored)
- cmd_pcid  in  SPCID  PCID (lookup/insert/invalidate)
- resp_valid  out  1  one-cycle response pulse
- resp_hit  out  1  lookup: hit; insert: existing entry updated in place
- resp_ta  out  SADDR  translated address (lookup hit), else 0
- resp_way  out  log2(NWAY)  way hit or written, else 0

## Operation
- Address split: offset = va[SPAGE-1:0]; set = va[SPAGE+log2(NSET)-1:SPAGE]; tag = remaining upper bits.
- Entry fields: valid, tag, pcid, ppn (SADDR-SPAGE bits). A match requires valid, equal tag and equal pcid.
- PLRU: NWAY-1 bits per set, heap-ordered (root node 0, children 2i+1 and 2i+2). Bit 0 means the victim lies in the left subtree.
  - Touch(w): set every bit on the path to w so it points away from w.
  - Victim: follow the bits from the root.
- States: IDLE, LOOKUP, INSERT, INV, FLUSH.
  - A command is accepted on an edge where cmd_valid and cmd_ready are both high.
  - The command fields are registered at acceptance and decoded to the state for cmd_op.
- LOOKUP: compare all ways of the registered set in parallel.
  - Hit: resp_hit=1, resp_ta={ppn, offset}, resp_way=w, Touch(w).
  - Miss: resp_hit=0, resp_ta=0, resp_way=0, PLRU unchanged.
  - Next state: IDLE.
- INSERT: way selection, in priority order:
  - Matching entry: overwrite its ppn, resp_hit=1.
  - Else the lowest-index invalid way.
  - Else the PLRU victim.
  - In every case: write valid=1, tag, pcid, ppn; Touch(way); resp_way=way; resp_ta=0. Next state: IDLE.
- INV: a set counter walks sets 0..NSET-1, one set per cycle. Every way whose pcid equals the registered pcid gets valid cleared. PLRU is untouched. After set NSET-1, assert resp_valid and go to IDLE.
- FLUSH: clear all valid bits and all PLRU bits in one cycle, assert resp_valid, go to IDLE.
- For INV and FLUSH, resp_hit, resp_ta and resp_way are 0.
- cmd_valid while cmd_ready is low is ignored; the requester holds the command.

## Timing
- Reset values: state IDLE, cmd_ready=1, resp_valid=0, resp_hit=0, resp_ta=0, resp_way=0, all valid bits 0, all PLRU bits 0, set counter 0.
- Reset asserted mid-operation aborts immediately. No response is issued for the aborted command. The block is in IDLE with cmd_ready=1 on the first edge after rst deasserts.
- The response is registered and updated on the edge where the command's state completes.
  - Lookup/insert/flush: accepted at edge E0, resp_valid high for the cycle after E1, cmd_ready high again after E1. Throughput is one command per 2 cycles.
  - Invalidate: resp_valid high after E0+NSET. cmd_ready is low for NSET cycles.
- resp_valid is a single-cycle pulse. The resp_* data fields hold their value until the next response.
- Entry and PLRU writes from an insert take effect at E1. A lookup accepted at E1 sees them.
- A lookup that follows an invalidate or flush sees the cleared state.

## Test plan
- Reset, then lookup va=0x1234 pcid=1 → one cycle after the second edge: resp_valid=1, resp_hit=0, resp_ta=0. cmd_ready low exactly one cycle.
- Insert va=0x5000 pa=0xABC000 pcid=3 → resp_way=0, resp_hit=0. Then lookup va=0x5123 pcid=3 → hit, resp_ta=0xABC123. Lookup va=0x5123 pcid=4 → miss.
- Fill set 0 with tags 1..8 (va=tag<<15, pcid=0) → resp_way 0..7 in order. Then:
  - lookup tag 1 → hit way 0;
  - insert tag 9 → PLRU victim way 4;
  - lookup tag 5 → miss, lookup tag 9 → hit way 4.
- Re-insert va=0x5000 pcid=3 with pa=0xDEF000 → resp_hit=1, same way. Lookup va=0x5010 → resp_ta=0xDEF010, and no second valid copy exists.
- Insert entries with pcid 3 and pcid 5 in different sets, then invalidate pcid=3 → cmd_ready low 8 cycles, then resp_valid. The pcid-3 lookup misses; the pcid-5 lookup hits.
- Raise rst during the INV walk (cycle 3) → all outputs at reset values without waiting for a clock edge, no resp_valid issued. Every prior entry then misses.
